// File: rtl/k6502_defs.sv
// Shared definitions for the k6502 CPU core: debug timing-state width, opcode
// constants, timing-state encodings (T0..T6 plus reset cycles R0/R1), status
// flag bit positions and the ALU operation select.
package k6502_defs;

  localparam int unsigned X_BITS = 3;

  // Supported opcodes; anything else runs as a 2-cycle NOP.
  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_CLC     = 8'h18;
  localparam logic [7:0] OP_SEC     = 8'h38;
  localparam logic [7:0] OP_TAX     = 8'hAA;
  localparam logic [7:0] OP_TXA     = 8'h8A;
  localparam logic [7:0] OP_INX     = 8'hE8;
  localparam logic [7:0] OP_DEX     = 8'hCA;
  localparam logic [7:0] OP_INY     = 8'hC8;
  localparam logic [7:0] OP_DEY     = 8'h88;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_LDX_IMM = 8'hA2;
  localparam logic [7:0] OP_LDY_IMM = 8'hA0;
  localparam logic [7:0] OP_ADC_IMM = 8'h69;
  localparam logic [7:0] OP_JMP_ABS = 8'h4C;
  localparam logic [7:0] OP_LDA_ABS = 8'hAD;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_STX_ABS = 8'h8E;
  localparam logic [7:0] OP_BNE     = 8'hD0;
  localparam logic [7:0] OP_BEQ     = 8'hF0;

  // Low three bits are the debug timing state; R0/R1 read back as 0/1.
  typedef enum logic [3:0] {
    T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3,
    T4 = 4'd4, T5 = 4'd5, T6 = 4'd6,
    R0 = 4'd8, R1 = 4'd9
  } tstate_e;

  localparam int unsigned FLAG_C = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_V = 6;
  localparam int unsigned FLAG_N = 7;

  typedef enum logic [1:0] {
    AluPass,
    AluInc,
    AluDec,
    AluAdd
  } alu_op_e;

endpackage

// File: rtl/k6502_alu.sv
// k6502 ALU: combinational pass/increment/decrement/add-with-carry.
// Ports: op (operation), a_in/b_in (operands), c_in (carry in),
//        res (8-bit result), n/z/c/v (flag results; c/v meaningful for add only).
module k6502_alu
  import k6502_defs::*;
(
  input  alu_op_e    op,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic       c_in,
  output logic [7:0] res,
  output logic       n,
  output logic       z,
  output logic       c,
  output logic       v
);

  logic [8:0] sum;

  always_comb begin
    sum = {1'b0, a_in} + {1'b0, b_in} + {8'd0, c_in};
    res = a_in;
    c   = 1'b0;
    v   = 1'b0;
    unique case (op)
      AluPass: res = a_in;
      AluInc:  res = a_in + 8'd1;
      AluDec:  res = a_in - 8'd1;
      AluAdd: begin
        res = sum[7:0];
        c   = sum[8];
        // Overflow: operands share a sign that the result does not.
        v   = (a_in[7] == b_in[7]) && (sum[7] != a_in[7]);
      end
      default: res = a_in;
    endcase
    n = res[7];
    z = (res == 8'd0);
  end

endmodule

// File: rtl/k6502_cpu.sv
// k6502 CPU core: 6502-compatible subset, one bus cycle per clock.
// Ports: clk, rst_n (async active-low), a (address, registered), d (bidir data,
//        driven only while rw=0), rw (1=read), sync (opcode fetch cycle),
//        debug x (timing state), pc, dl (operand latch), ir (instruction).
module k6502_cpu
  import k6502_defs::*;
#(
  parameter logic [15:0] RESET_VEC = 16'hFFFC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [15:0]       a,
  inout  wire  [7:0]        d,
  output logic              rw,
  output logic              sync,
  output logic [X_BITS-1:0] x,
  output logic [15:0]       pc,
  output logic [15:0]       dl,
  output logic [7:0]        ir
);

  tstate_e     state_q, state_d;
  logic [15:0] a_q, a_d, pc_q, pc_d, dl_q, dl_d;
  logic [7:0]  ir_q, ir_d, dout_q, dout_d;
  logic [7:0]  ra_q, ra_d, rx_q, rx_d, ry_q, ry_d, p_q, p_d;
  logic        rw_q, rw_d, sync_q, sync_d;

  alu_op_e     alu_op;
  logic [7:0]  alu_a, alu_b, alu_res;
  logic        alu_n, alu_z, alu_c, alu_v;
  logic        wb_a, wb_x, wb_y, wb_cv, fetch, taken;

  k6502_alu u_alu (
    .op   (alu_op),
    .a_in (alu_a),
    .b_in (alu_b),
    .c_in (p_q[FLAG_C]),
    .res  (alu_res),
    .n    (alu_n),
    .z    (alu_z),
    .c    (alu_c),
    .v    (alu_v)
  );

  assign taken = (ir_q == OP_BNE) ? !p_q[FLAG_Z] : p_q[FLAG_Z];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    rw_d    = 1'b1;
    sync_d  = 1'b0;
    dout_d  = dout_q;
    pc_d    = pc_q;
    dl_d    = dl_q;
    ir_d    = ir_q;
    ra_d    = ra_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    p_d     = p_q;
    alu_op  = AluPass;
    alu_a   = d;
    alu_b   = d;
    wb_a    = 1'b0;
    wb_x    = 1'b0;
    wb_y    = 1'b0;
    wb_cv   = 1'b0;
    fetch   = 1'b0;
    unique case (state_q)
      R0: begin
        dl_d[7:0] = d;
        a_d       = RESET_VEC + 16'd1;
        state_d   = R1;
      end
      R1: begin
        dl_d[15:8] = d;
        pc_d       = {d, dl_q[7:0]};
        fetch      = 1'b1;
      end
      T0: begin
        ir_d    = d;
        pc_d    = pc_q + 16'd1;
        a_d     = pc_q + 16'd1;
        state_d = T1;
      end
      T1: begin
        case (ir_q)
          OP_LDA_IMM: begin pc_d = pc_q + 16'd1; wb_a = 1'b1; fetch = 1'b1; end
          OP_LDX_IMM: begin pc_d = pc_q + 16'd1; wb_x = 1'b1; fetch = 1'b1; end
          OP_LDY_IMM: begin pc_d = pc_q + 16'd1; wb_y = 1'b1; fetch = 1'b1; end
          OP_ADC_IMM: begin
            alu_op = AluAdd;
            alu_a  = ra_q;
            pc_d   = pc_q + 16'd1;
            wb_a   = 1'b1;
            wb_cv  = 1'b1;
            fetch  = 1'b1;
          end
          // Implied ops: the cycle's read at pc is a dummy, pc is held.
          OP_TAX: begin alu_a = ra_q; wb_x = 1'b1; fetch = 1'b1; end
          OP_TXA: begin alu_a = rx_q; wb_a = 1'b1; fetch = 1'b1; end
          OP_INX: begin alu_op = AluInc; alu_a = rx_q; wb_x = 1'b1; fetch = 1'b1; end
          OP_DEX: begin alu_op = AluDec; alu_a = rx_q; wb_x = 1'b1; fetch = 1'b1; end
          OP_INY: begin alu_op = AluInc; alu_a = ry_q; wb_y = 1'b1; fetch = 1'b1; end
          OP_DEY: begin alu_op = AluDec; alu_a = ry_q; wb_y = 1'b1; fetch = 1'b1; end
          OP_CLC: begin p_d[FLAG_C] = 1'b0; fetch = 1'b1; end
          OP_SEC: begin p_d[FLAG_C] = 1'b1; fetch = 1'b1; end
          OP_JMP_ABS, OP_LDA_ABS, OP_STA_ABS, OP_STX_ABS: begin
            dl_d[7:0] = d;
            pc_d      = pc_q + 16'd1;
            a_d       = pc_q + 16'd1;
            state_d   = T2;
          end
          OP_BNE, OP_BEQ: begin
            dl_d[7:0] = d;
            pc_d      = pc_q + 16'd1;
            if (taken) begin
              a_d     = pc_q + 16'd1;
              state_d = T2;
            end else begin
              fetch = 1'b1;
            end
          end
          default: fetch = 1'b1;
        endcase
      end
      T2: begin
        case (ir_q)
          OP_JMP_ABS: begin
            dl_d[15:8] = d;
            pc_d       = {d, dl_q[7:0]};
            fetch      = 1'b1;
          end
          OP_LDA_ABS, OP_STA_ABS, OP_STX_ABS: begin
            dl_d[15:8] = d;
            pc_d       = pc_q + 16'd1;
            a_d        = {d, dl_q[7:0]};
            state_d    = T3;
            if (ir_q == OP_STA_ABS) begin
              rw_d   = 1'b0;
              dout_d = ra_q;
            end else if (ir_q == OP_STX_ABS) begin
              rw_d   = 1'b0;
              dout_d = rx_q;
            end
          end
          // Taken branch: pc already points past the offset byte.
          OP_BNE, OP_BEQ: begin
            pc_d  = pc_q + {{8{dl_q[7]}}, dl_q[7:0]};
            fetch = 1'b1;
          end
          default: fetch = 1'b1;
        endcase
      end
      T3: begin
        if (ir_q == OP_LDA_ABS) wb_a = 1'b1;
        fetch = 1'b1;
      end
      default: fetch = 1'b1;
    endcase

    if (wb_a) ra_d = alu_res;
    if (wb_x) rx_d = alu_res;
    if (wb_y) ry_d = alu_res;
    if (wb_a || wb_x || wb_y) begin
      p_d[FLAG_N] = alu_n;
      p_d[FLAG_Z] = alu_z;
    end
    if (wb_cv) begin
      p_d[FLAG_C] = alu_c;
      p_d[FLAG_V] = alu_v;
    end
    if (fetch) begin
      a_d     = pc_d;
      sync_d  = 1'b1;
      state_d = T0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= R0;
      a_q     <= RESET_VEC;
      rw_q    <= 1'b1;
      sync_q  <= 1'b0;
      dout_q  <= 8'h00;
      pc_q    <= 16'h0000;
      dl_q    <= 16'h0000;
      ir_q    <= OP_NOP;
      ra_q    <= 8'h00;
      rx_q    <= 8'h00;
      ry_q    <= 8'h00;
      p_q     <= 8'h00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      rw_q    <= rw_d;
      sync_q  <= sync_d;
      dout_q  <= dout_d;
      pc_q    <= pc_d;
      dl_q    <= dl_d;
      ir_q    <= ir_d;
      ra_q    <= ra_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      p_q     <= p_d;
    end
  end

  assign d    = rw_q ? 8'hzz : dout_q;
  assign a    = a_q;
  assign rw   = rw_q;
  assign sync = sync_q;
  assign x    = state_q[X_BITS-1:0];
  assign pc   = pc_q;
  assign dl   = dl_q;
  assign ir   = ir_q;

endmodule

// File: tb/tb_k6502_cpu.sv
// Directed self-checking bench for k6502_cpu with a flat 64 KiB memory model.
module tb_k6502_cpu;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  wire  [7:0]  d;
  logic        rw;
  logic        sync;
  logic [2:0]  x;
  logic [15:0] pc;
  logic [15:0] dl;
  logic [7:0]  ir;

  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  int          wr_count;
  int          checks;
  int          failures;

  k6502_cpu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .d     (d),
    .rw    (rw),
    .sync  (sync),
    .x     (x),
    .pc    (pc),
    .dl    (dl),
    .ir    (ir)
  );

  assign d = (rw === 1'b1) ? mem[a] : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rw === 1'b0) begin
      wr_addr  = a;
      wr_data  = d;
      wr_count = wr_count + 1;
    end
  end

  task automatic load_prog(input logic [255:0] bytes, input int n);
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
    mem[16'hFFFC] = 8'h00;
    mem[16'hFFFD] = 8'h80;
    for (int i = 0; i < n; i++) mem[16'h8000 + i] = bytes[8*(n-1-i) +: 8];
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_fetch(input logic [15:0] addr, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!(sync === 1'b1 && a === addr) && cycles < 100);
  endtask

  task automatic test_reset();
    int cyc;
    load_prog(256'h0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({a, rw, sync, x, ir} !== {16'hFFFC, 1'b1, 1'b0, 3'd0, 8'hEA}) begin
      failures++;
      $display("FAIL reset_bus: got a=%h rw=%b sync=%b x=%0d ir=%h want FFFC 1 0 0 EA",
               a, rw, sync, x, ir);
    end
    checks++;
    if ({pc, dl, dut.ra_q, dut.rx_q, dut.ry_q, dut.p_q} !== 64'h0) begin
      failures++;
      $display("FAIL reset_regs: got pc=%h dl=%h A=%h X=%h Y=%h P=%h want all zero",
               pc, dl, dut.ra_q, dut.rx_q, dut.ry_q, dut.p_q);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({a, rw, sync, x} !== {16'hFFFD, 1'b1, 1'b0, 3'd1}) begin
      failures++;
      $display("FAIL reset_r1: got a=%h rw=%b sync=%b x=%0d want FFFD 1 0 1", a, rw, sync, x);
    end
    @(negedge clk);
    checks++;
    if ({a, sync, x, pc, dl} !== {16'h8000, 1'b1, 3'd0, 16'h8000, 16'h8000}) begin
      failures++;
      $display("FAIL reset_fetch: got a=%h sync=%b x=%0d pc=%h dl=%h want 8000 1 0 8000 8000",
               a, sync, x, pc, dl);
    end
    cyc = 0;
    apply_reset();
    run_to_fetch(16'h8000, cyc);
    checks++;
    if (cyc !== 2) begin
      failures++;
      $display("FAIL reset_seq_len: got %0d cycles want 2", cyc);
    end
  endtask

  task automatic test_lda_sta();
    int cyc;
    logic [15:0] ea [0:6];
    logic [2:0]  ex [0:6];
    logic        ew [0:6];
    logic        es [0:6];
    ea = '{16'h8000, 16'h8001, 16'h8002, 16'h8003, 16'h8004, 16'h0200, 16'h8005};
    ex = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    ew = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    es = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    load_prog(256'hA9_5A_8D_00_02, 5);
    apply_reset();
    run_to_fetch(16'h8000, cyc);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if ({a, rw, sync, x} !== {ea[i], ew[i], es[i], ex[i]}) begin
        failures++;
        $display("FAIL lda_sta_cycle%0d: got a=%h rw=%b sync=%b x=%0d want %h %b %b %0d",
                 i + 1, a, rw, sync, x, ea[i], ew[i], es[i], ex[i]);
      end
      if (i == 5) begin
        checks++;
        if (d !== 8'h5A) begin
          failures++;
          $display("FAIL sta_data: got d=%h want 5A", d);
        end
      end
      if (i < 6) @(negedge clk);
    end
  endtask

  task automatic test_jmp();
    int cyc;
    load_prog(256'h4C_34_92, 3);
    apply_reset();
    run_to_fetch(16'h8000, cyc);
    run_to_fetch(16'h9234, cyc);
    checks++;
    if ({cyc[7:0], ir, pc, dl} !== {8'd3, 8'h4C, 16'h9234, 16'h9234}) begin
      failures++;
      $display("FAIL jmp: got cycles=%0d ir=%h pc=%h dl=%h want 3 4C 9234 9234",
               cyc, ir, pc, dl);
    end
  endtask

  task automatic test_count_loop();
    int cyc;
    int dex;
    int wc;
    load_prog(256'hA2_03_CA_D0_FD_8E_00_03_F0_02, 10);
    apply_reset();
    run_to_fetch(16'h8000, cyc);
    cyc = 0;
    dex = 0;
    while (!(sync === 1'b1 && a === 16'h8005) && cyc < 100) begin
      if (sync === 1'b1 && a === 16'h8002) dex++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc !== 16) begin
      failures++;
      $display("FAIL loop_cycles: got %0d want 16", cyc);
    end
    checks++;
    if (dex !== 3) begin
      failures++;
      $display("FAIL loop_dex_count: got %0d want 3", dex);
    end
    wc = wr_count;
    run_to_fetch(16'h8008, cyc);
    checks++;
    if ({cyc[7:0], wr_addr, wr_data} !== {8'd4, 16'h0300, 8'h00} || wr_count !== wc + 1) begin
      failures++;
      $display("FAIL loop_stx: got cycles=%0d addr=%h data=%h writes=%0d want 4 0300 00 %0d",
               cyc, wr_addr, wr_data, wr_count - wc, 1);
    end
    run_to_fetch(16'h800C, cyc);
    checks++;
    if (cyc !== 3) begin
      failures++;
      $display("FAIL loop_beq_taken: got %0d cycles want 3", cyc);
    end
  endtask

  task automatic test_adc();
    int cyc;
    load_prog(256'h38_A9_7F_69_00_8D_00_04_18_69_80_8D_01_04, 14);
    apply_reset();
    run_to_fetch(16'h8000, cyc);
    run_to_fetch(16'h8008, cyc);
    checks++;
    if ({cyc[7:0], wr_addr, wr_data} !== {8'd10, 16'h0400, 8'h80}) begin
      failures++;
      $display("FAIL adc_overflow_store: got cycles=%0d addr=%h data=%h want 10 0400 80",
               cyc, wr_addr, wr_data);
    end
    checks++;
    if ({dut.p_q[7], dut.p_q[6], dut.p_q[1], dut.p_q[0]} !== 4'b1100) begin
      failures++;
      $display("FAIL adc_overflow_flags: got NVZC=%b%b%b%b want 1100",
               dut.p_q[7], dut.p_q[6], dut.p_q[1], dut.p_q[0]);
    end
    run_to_fetch(16'h800E, cyc);
    checks++;
    if ({cyc[7:0], wr_addr, wr_data} !== {8'd8, 16'h0401, 8'h00}) begin
      failures++;
      $display("FAIL adc_carry_store: got cycles=%0d addr=%h data=%h want 8 0401 00",
               cyc, wr_addr, wr_data);
    end
    checks++;
    if ({dut.p_q[7], dut.p_q[6], dut.p_q[1], dut.p_q[0]} !== 4'b0111) begin
      failures++;
      $display("FAIL adc_carry_flags: got NVZC=%b%b%b%b want 0111",
               dut.p_q[7], dut.p_q[6], dut.p_q[1], dut.p_q[0]);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    load_prog(256'hA2_FF_E8_8E_00_06_A9_81_AA_CA_8A_8D_01_06_A0_00_88_C8_C8, 19);
    apply_reset();
    run_to_fetch(16'h8000, cyc);
    run_to_fetch(16'h8006, cyc);
    checks++;
    if ({cyc[7:0], wr_addr, wr_data} !== {8'd8, 16'h0600, 8'h00}) begin
      failures++;
      $display("FAIL inx_wrap: got cycles=%0d addr=%h data=%h want 8 0600 00",
               cyc, wr_addr, wr_data);
    end
    run_to_fetch(16'h800E, cyc);
    checks++;
    if ({cyc[7:0], wr_addr, wr_data} !== {8'd12, 16'h0601, 8'h80}) begin
      failures++;
      $display("FAIL tax_dex_txa: got cycles=%0d addr=%h data=%h want 12 0601 80",
               cyc, wr_addr, wr_data);
    end
    run_to_fetch(16'h8013, cyc);
    checks++;
    if ({cyc[7:0], dut.ry_q, dut.p_q[7], dut.p_q[1]} !== {8'd8, 8'h01, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL dey_iny: got cycles=%0d Y=%h N=%b Z=%b want 8 01 0 0",
               cyc, dut.ry_q, dut.p_q[7], dut.p_q[1]);
    end
  endtask

  task automatic test_unknown();
    int cyc;
    load_prog(256'hA9_33_02_8D_00_05, 6);
    apply_reset();
    run_to_fetch(16'h8000, cyc);
    run_to_fetch(16'h8002, cyc);
    run_to_fetch(16'h8003, cyc);
    checks++;
    if ({cyc[7:0], pc, dut.ra_q, dut.rx_q} !== {8'd2, 16'h8003, 8'h33, 8'h00}) begin
      failures++;
      $display("FAIL unknown_op: got cycles=%0d pc=%h A=%h X=%h want 2 8003 33 00",
               cyc, pc, dut.ra_q, dut.rx_q);
    end
    run_to_fetch(16'h8006, cyc);
    checks++;
    if ({cyc[7:0], wr_addr, wr_data} !== {8'd4, 16'h0500, 8'h33}) begin
      failures++;
      $display("FAIL unknown_then_sta: got cycles=%0d addr=%h data=%h want 4 0500 33",
               cyc, wr_addr, wr_data);
    end
  endtask

  task automatic test_reset_mid_sta();
    int cyc;
    load_prog(256'hA9_5A_8D_00_02, 5);
    apply_reset();
    run_to_fetch(16'h8000, cyc);
    cyc = 0;
    while (rw !== 1'b0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (rw !== 1'b0) begin
      failures++;
      $display("FAIL mid_sta_reach_write: got rw=%b want 0", rw);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({a, rw, sync, x} !== {16'hFFFC, 1'b1, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL mid_sta_async_reset: got a=%h rw=%b sync=%b x=%0d want FFFC 1 0 0",
               a, rw, sync, x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_to_fetch(16'h8000, cyc);
    checks++;
    if (cyc !== 2) begin
      failures++;
      $display("FAIL mid_sta_restart: got %0d cycles want 2", cyc);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wr_count = 0;
    wr_addr  = 16'h0;
    wr_data  = 8'h0;
    rst_n    = 1'b1;
    #2 rst_n = 1'b0;
    test_reset();
    test_lda_sta();
    test_jmp();
    test_count_loop();
    test_adc();
    test_back_to_back();
    test_unknown();
    test_reset_mid_sta();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
